qspi_latency_line: RTL and testbench
====================================

QSPI_LATENCY_LINE -- requirements
Module: qspi_latency_line

Interface
REQ-001 SHALL have parameter DATA_W, default 4: QSPI data lanes carried.
REQ-002 SHALL have parameter MAX_LAT, default 8: deepest delay in clk cycles.
REQ-003 SHALL have parameter NUM_CH, default 3: chip-select channels (flash, ram_a, ram_b).
REQ-004 SHALL have derived localparam LAT_W = clog2(MAX_LAT+1).
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  clock; rst  in  1  reset.
REQ-006 SHALL have port sel_n  in  NUM_CH  active-low chip selects, bit i = channel i.
REQ-007 SHALL have port lat_cfg  in  NUM_CH*LAT_W  per-channel latency, channel i at [i*LAT_W +: LAT_W].
REQ-008 SHALL have port data_in  in  DATA_W  undelayed read data from the device model.
REQ-009 SHALL have port data_out  out  DATA_W  delayed read data to the core.
REQ-010 SHALL have port data_out_valid  out  1  delay line filled for the current transaction.
REQ-011 SHALL have port active_ch  out  clog2(NUM_CH)  channel of the current transaction.
REQ-012 SHALL have port sel_conflict  out  1  sticky flag: more than one select was low in the same cycle.

Function
REQ-013 SHALL shift data_in into a MAX_LAT-deep stage array every clk cycle, regardless of the selects.
REQ-014 SHALL treat a transaction as started in a cycle where any sel_n bit is low and either:
- no sel_n bit was low in the previous cycle; or
- the lowest-index low bit differs from the previous cycle's.
REQ-015 SHALL, in the start cycle, latch the channel and its lat_cfg field as L, clamping values above MAX_LAT to MAX_LAT.
REQ-016 SHALL ignore lat_cfg changes during a transaction; the latched L holds until the next start.
REQ-017 SHALL resolve simultaneous low selects to the lowest index and set sel_conflict, which holds until rst.
REQ-018 SHALL keep a fill counter that:
- reads 0 in the start cycle;
- increments once per cycle while selected;
- saturates at MAX_LAT.
REQ-019 SHALL drive data_out_valid = 1 while selected and fill count >= L; for L=0 it is 1 in the start cycle.
REQ-020 SHALL drive data_out as follows:
- L=0 and valid: data_in, combinationally;
- L>0 and valid: the stage holding data_in from exactly L cycles earlier;
- otherwise: all zeros.
REQ-021 SHALL, once all selects return high, drive data_out to zero and data_out_valid to 0 in the same cycle; active_ch holds its last value.
REQ-022 SHALL restart the fill count at 0 on a direct switch from one channel to another, with no idle cycle.

Reset
REQ-023 SHALL, while rst is high, clear asynchronously the stages, fill count, latched L, active_ch and sel_conflict.
REQ-024 SHALL hold data_out = 0 and data_out_valid = 0 during rst and in the first cycle after release.
REQ-025 SHALL treat a select already low when rst deasserts as a transaction start in the first clocked cycle.
REQ-026 SHALL abort a transaction in progress when rst asserts, with no residual valid.

Structure
REQ-027 SHALL place the shared package contents as follows:
- shared package qspi_pkg: channel index constants CH_FLASH=0, CH_RAM_A=1, CH_RAM_B=2;
- also in qspi_pkg: the default latency constant.
REQ-028 SHALL use one sub-module, qspi_delay_stages: the parametrised shift array exposing all taps.
- Control and tap mux stay in the top level.

Verification
REQ-029 SHALL verify L=0 on the flash channel:
- stimulus: flash selected, data_in = 0xA;
- response: data_out = 0xA and valid = 1 in the same cycle.
REQ-030 SHALL verify a ram_a delay of 3:
- stimulus: lat_cfg ram_a = 3, data_in sequence 1,2,3,4,5 from the start cycle;
- response: valid rises in cycle 3, and data_out reads 1,2 in cycles 3,4.
REQ-031 SHALL verify clamping:
- stimulus: lat_cfg = 15 with MAX_LAT = 8;
- response: behaves as L = 8, valid rises in cycle 8.
REQ-032 SHALL verify a direct channel switch:
- stimulus: ram_a (L=2) to ram_b (L=5) with no idle cycle;
- response: valid drops, then returns 5 cycles later, and active_ch = 2.
REQ-033 SHALL verify a select conflict:
- stimulus: sel_n = 3'b100;
- response: active_ch = 0, sel_conflict = 1, and it stays 1 after the selects go idle until rst.
REQ-034 SHALL verify reset mid-transaction:
- stimulus: rst pulsed while valid = 1;
- response: data_out = 0 and valid = 0 immediately, then a fresh fill of L cycles after release.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared QSPI constants: chip-select channel indices and the default read latency.
package qspi_pkg;

    localparam int CH_FLASH = 0;
    localparam int CH_RAM_A = 1;
    localparam int CH_RAM_B = 2;

    localparam int QSPI_DEFAULT_LAT = 8;

endpackage

// File: rtl/qspi_delay_stages.sv
// Free-running shift array; tap i holds data_in from i+1 cycles ago.
module qspi_delay_stages
    import qspi_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = QSPI_DEFAULT_LAT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         data_in,
    output logic [DEPTH*DATA_W-1:0]   taps
);

    logic [DATA_W-1:0] stage_r [DEPTH];

    // Shift every cycle; selects have no influence on the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    // Flatten the stages onto the tap bus.
    always_comb begin
        taps = '0;
        for (int i = 0; i < DEPTH; i++) begin
            taps[i*DATA_W +: DATA_W] = stage_r[i];
        end
    end

endmodule

// File: rtl/qspi_latency_line.sv
// Per-channel programmable read-data delay for a QSPI controller; tracks the
// active chip select, its latched latency and the fill state of the delay line.
module qspi_latency_line
    import qspi_pkg::*;
#(
    parameter  int DATA_W  = 4,
    parameter  int MAX_LAT = QSPI_DEFAULT_LAT,
    parameter  int NUM_CH  = 3,
    localparam int LAT_W   = $clog2(MAX_LAT + 1),
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         sel_n,
    input  logic [NUM_CH*LAT_W-1:0]   lat_cfg,
    input  logic [DATA_W-1:0]         data_in,
    output logic [DATA_W-1:0]         data_out,
    output logic                      data_out_valid,
    output logic [CH_W-1:0]           active_ch,
    output logic                      sel_conflict
);

    logic [MAX_LAT*DATA_W-1:0] taps_s;
    logic                      live_r;
    logic                      prev_any_r;
    logic [CH_W-1:0]           active_ch_r;
    logic [LAT_W-1:0]          lat_r;
    logic [LAT_W-1:0]          fill_r;
    logic                      conflict_r;

    logic                      any_low_s;
    logic                      multi_low_s;
    logic                      seen_s;
    logic [CH_W-1:0]           low_idx_s;
    logic [LAT_W-1:0]          lat_field_s;
    logic [LAT_W-1:0]          lat_clamped_s;
    logic                      start_s;
    logic [LAT_W-1:0]          lat_cur_s;
    logic [LAT_W-1:0]          fill_cur_s;
    logic                      valid_s;
    logic [DATA_W-1:0]         data_tap_s;

    qspi_delay_stages #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_LAT)
    ) u_stages (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .taps    (taps_s)
    );

    // Select decode: lowest-index low bit wins, more than one low is a conflict.
    always_comb begin
        any_low_s   = 1'b0;
        multi_low_s = 1'b0;
        seen_s      = 1'b0;
        low_idx_s   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!sel_n[i]) begin
                low_idx_s = CH_W'(i);
                any_low_s = 1'b1;
                if (seen_s) begin
                    multi_low_s = 1'b1;
                end else begin
                    seen_s = 1'b1;
                end
            end else begin
                seen_s = seen_s;
            end
        end
    end

    // Transaction start, latency selection and fill/valid evaluation.
    always_comb begin
        lat_field_s   = lat_cfg[int'(low_idx_s)*LAT_W +: LAT_W];
        if (lat_field_s > LAT_W'(MAX_LAT)) begin
            lat_clamped_s = LAT_W'(MAX_LAT);
        end else begin
            lat_clamped_s = lat_field_s;
        end
        // Before the first edge after reset the line stays silent; the start is seen one cycle later.
        start_s    = live_r && any_low_s && (!prev_any_r || (low_idx_s != active_ch_r));
        lat_cur_s  = start_s ? lat_clamped_s : lat_r;
        fill_cur_s = start_s ? '0 : fill_r;
        valid_s    = live_r && any_low_s && (fill_cur_s >= lat_cur_s);
    end

    // Tap mux: a latency of L reads the stage that is L cycles old.
    always_comb begin
        data_tap_s = '0;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (lat_cur_s == LAT_W'(i + 1)) begin
                data_tap_s = taps_s[i*DATA_W +: DATA_W];
            end else begin
                data_tap_s = data_tap_s;
            end
        end
        if (!valid_s) begin
            data_out = '0;
        end else if (lat_cur_s == '0) begin
            data_out = data_in;
        end else begin
            data_out = data_tap_s;
        end
        data_out_valid = valid_s;
        active_ch      = start_s ? low_idx_s : active_ch_r;
        sel_conflict   = conflict_r | (multi_low_s & ~rst);
    end

    // Control state: channel/latency latch, saturating fill count, sticky conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_r      <= 1'b0;
            prev_any_r  <= 1'b0;
            active_ch_r <= '0;
            lat_r       <= '0;
            fill_r      <= '0;
            conflict_r  <= 1'b0;
        end else begin
            live_r     <= 1'b1;
            conflict_r <= conflict_r | multi_low_s;
            if (live_r) begin
                prev_any_r <= any_low_s;
                if (start_s) begin
                    active_ch_r <= low_idx_s;
                    lat_r       <= lat_clamped_s;
                end
                if (!any_low_s) begin
                    fill_r <= '0;
                end else if (fill_cur_s == LAT_W'(MAX_LAT)) begin
                    fill_r <= LAT_W'(MAX_LAT);
                end else begin
                    fill_r <= fill_cur_s + LAT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_qspi_latency_line.sv
// Bench for qspi_latency_line: vector table, directed corner sequences and
// randomized traffic against a history-based reference model.
module tb_qspi_latency_line;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sel_n;
    logic [11:0] lat_cfg;
    logic [3:0]  data_in;
    logic [3:0]  data_out;
    logic        data_out_valid;
    logic [1:0]  active_ch;
    logic        sel_conflict;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [3:0] hist[$];
    bit  m_live;
    bit  m_prev_any;
    int  m_act;
    int  m_start;
    int  m_lat;
    bit  m_conflict;

    // outputs sampled in the most recent step
    int o_valid, o_data, o_ch, o_conf;

    typedef struct {
        logic [2:0]  sel;
        logic [11:0] lat;
        logic [3:0]  din;
        int          ev;
        int          ed;
    } vec_t;
    vec_t tbl[$];

    qspi_latency_line #(.DATA_W(4), .MAX_LAT(8), .NUM_CH(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .sel_n          (sel_n),
        .lat_cfg        (lat_cfg),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .active_ch      (active_ch),
        .sel_conflict   (sel_conflict)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] mk(input int f, input int a, input int b);
        logic [11:0] w;
        w = {4'(b), 4'(a), 4'(f)};
        return w;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, predict, sample mid-cycle, then advance the model.
    task automatic step(input logic [2:0] s, input logic [11:0] lc, input logic [3:0] d);
        bit any;
        int idx, nlow, cyc, f, ev, ed;
        sel_n = s; lat_cfg = lc; data_in = d;
        hist.push_back(d);
        cyc  = hist.size() - 1;
        nlow = 0; idx = 0;
        for (int i = 2; i >= 0; i--) begin
            if (!s[i]) begin nlow++; idx = i; end
        end
        any = (nlow > 0);
        if (m_live && any && (!m_prev_any || idx != m_act)) begin
            f = (lc >> (idx * 4)) & 15;
            m_lat   = (f > 8) ? 8 : f;
            m_start = cyc;
            m_act   = idx;
        end
        ev = (m_live && any && (cyc - m_start >= m_lat)) ? 1 : 0;
        ed = 0;
        if (ev == 1) ed = (m_lat == 0) ? int'(d) : int'(hist[cyc - m_lat]);
        #4;
        o_valid = int'(data_out_valid); o_data = int'(data_out);
        o_ch = int'(active_ch); o_conf = int'(sel_conflict);
        chk("model_valid", o_valid, ev);
        chk("model_data", o_data, ed);
        chk("model_active_ch", o_ch, m_act);
        chk("model_conflict", o_conf, (m_conflict || nlow > 1) ? 1 : 0);
        if (nlow > 1) m_conflict = 1'b1;
        if (m_live) m_prev_any = any;
        m_live = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Reset pulse starting just after an edge; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_data", int'(data_out), 0);
        chk("rst_valid", int'(data_out_valid), 0);
        chk("rst_active_ch", int'(active_ch), 0);
        chk("rst_conflict", int'(sel_conflict), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_live = 1'b0; m_prev_any = 1'b0; m_act = 0; m_conflict = 1'b0; m_lat = 0; m_start = 0;
    endtask

    initial begin
        logic [2:0]  rs;
        logic [3:0]  d0;
        rst = 1'b1; sel_n = 3'b111; lat_cfg = '0; data_in = '0;
        @(posedge clk);
        #1;
        do_reset();
        step(3'b111, 12'h000, 4'h0);

        // table: flash L=0, then ram_a L=3 with 1..5
        tbl.push_back('{3'b111, mk(0, 3, 0), 4'h0, 0, 0});
        tbl.push_back('{3'b110, mk(0, 3, 0), 4'hA, 1, 10});
        tbl.push_back('{3'b110, mk(0, 3, 0), 4'h5, 1, 5});
        tbl.push_back('{3'b111, mk(0, 3, 0), 4'h7, 0, 0});
        for (int i = 1; i <= 5; i++)
            tbl.push_back('{3'b101, mk(0, 3, 0), 4'(i), (i >= 4) ? 1 : 0, (i >= 4) ? i - 3 : 0});
        tbl.push_back('{3'b111, mk(0, 3, 0), 4'h9, 0, 0});
        foreach (tbl[i]) begin
            step(tbl[i].sel, tbl[i].lat, tbl[i].din);
            chk("tbl_valid", o_valid, tbl[i].ev);
            chk("tbl_data", o_data, tbl[i].ed);
        end

        // clamp: field 15 behaves as 8
        for (int i = 0; i < 10; i++) begin
            step(3'b110, mk(15, 0, 0), 4'(i + 1));
            if (i == 7) chk("clamp_valid_c7", o_valid, 0);
            if (i == 8) begin chk("clamp_valid_c8", o_valid, 1); chk("clamp_data_c8", o_data, 1); end
            if (i == 9) chk("clamp_data_c9", o_data, 2);
        end
        step(3'b111, 12'h000, 4'h0);

        // direct switch ram_a (L=2) -> ram_b (L=5)
        for (int i = 0; i < 4; i++) step(3'b101, mk(0, 2, 5), 4'($urandom_range(0, 15)));
        chk("sw_ram_a_valid", o_valid, 1);
        for (int j = 0; j < 7; j++) begin
            step(3'b011, mk(0, 2, 5), 4'($urandom_range(0, 15)));
            if (j == 0) chk("sw_drop", o_valid, 0);
            if (j == 4) chk("sw_still_filling", o_valid, 0);
            if (j == 5) begin chk("sw_return", o_valid, 1); chk("sw_active_ch", o_ch, 2); end
        end

        // select conflict: sticky until reset
        step(3'b100, mk(0, 0, 0), 4'h3);
        chk("cf_active_ch", o_ch, 0);
        chk("cf_flag", o_conf, 1);
        for (int i = 0; i < 3; i++) step(3'b111, 12'h000, 4'h0);
        chk("cf_sticky", o_conf, 1);
        do_reset();
        step(3'b111, 12'h000, 4'h0);
        chk("cf_cleared", o_conf, 0);

        // reset mid-transaction with select held low
        for (int i = 0; i < 4; i++) step(3'b110, mk(2, 0, 0), 4'(i + 4));
        chk("rm_valid_before", o_valid, 1);
        do_reset();
        step(3'b110, mk(2, 0, 0), 4'hF);
        chk("rm_first_cycle_valid", o_valid, 0);
        chk("rm_first_cycle_data", o_data, 0);
        d0 = 4'h6;
        step(3'b110, mk(2, 0, 0), d0);
        chk("rm_start_valid", o_valid, 0);
        step(3'b110, mk(2, 0, 0), 4'h1);
        chk("rm_fill1_valid", o_valid, 0);
        step(3'b110, mk(2, 0, 0), 4'h2);
        chk("rm_fill2_valid", o_valid, 1);
        chk("rm_fill2_data", o_data, int'(d0));

        // randomized traffic against the model
        rs = 3'b111;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            if ($urandom_range(0, 9) >= 7) begin
                case ($urandom_range(0, 4))
                    0: rs = 3'b111;
                    1: rs = 3'b110;
                    2: rs = 3'b101;
                    3: rs = 3'b011;
                    default: rs = 3'($urandom_range(0, 7));
                endcase
            end
            step(rs, 12'($urandom_range(0, 4095)), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
